// File: rtl/frame_mem_arbiter.sv
// Frame-buffer arbiter: shares one single-port 320x240 pixel memory between a
// raster-order stream writer and a fixed-latency random-access reader.
module frame_mem_arbiter #(
  parameter int COLS   = 320,
  parameter int ROWS   = 240,
  parameter int DATA_W = 32,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [COL_W-1:0]  rd_col,
  input  logic [ROW_W-1:0]  rd_row,
  output logic              rd_gnt,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  input  logic              frame_release,
  output logic              frame_full,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              mem_we,
  output logic              mem_re,
  output logic [COL_W-1:0]  mem_col,
  output logic [ROW_W-1:0]  mem_row,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dbg_state
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [COL_W-1:0]   wr_col_q;
  logic [ROW_W-1:0]   wr_row_q;
  logic               rr_wr_last_q;
  logic               wr_elig;
  logic               contested;
  logic               wr_fire;
  logic               rd_fire;
  logic               rd_in_range;
  logic               ptr_last_col;
  logic               ptr_last_row;
  logic               last_pixel;
  logic               rd_v1_q;
  logic               rd_err1_q;
  logic               rd_v2_q;
  logic               rd_err2_q;

  // Handshakes: a write transfers on a rising edge where wr_valid && wr_ready;
  // a read transfers where rd_req && rd_gnt. Ready/gnt never depend on a
  // transfer completing, and at most one of them is high in any cycle.
  always_comb begin
    wr_elig      = wr_valid && (state_q == FILL);
    contested    = wr_elig && rd_req;
    wr_fire      = wr_elig && (!rd_req || !rr_wr_last_q);
    rd_fire      = rd_req && !wr_fire;
    rd_in_range  = (rd_col < COL_W'(COLS)) && (rd_row < ROW_W'(ROWS));
    ptr_last_col = (wr_col_q == COL_W'(COLS - 1));
    ptr_last_row = (wr_row_q == ROW_W'(ROWS - 1));
    last_pixel   = wr_fire && ptr_last_col && ptr_last_row;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last_pixel) state_d = FULL;
      FULL:    if (frame_release) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  assign wr_ready   = wr_fire;
  assign rd_gnt     = rd_fire;
  assign frame_full = (state_q == FULL);
  assign dbg_state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      wr_col_q     <= '0;
      wr_row_q     <= '0;
      rr_wr_last_q <= 1'b1;
      frame_done   <= 1'b0;
      frame_count  <= '0;
    end else begin
      state_q    <= state_d;
      frame_done <= last_pixel;
      if (last_pixel) frame_count <= frame_count + 16'd1;
      // Round-robin memory only moves when both clients actually competed.
      if (contested) rr_wr_last_q <= wr_fire;
      if (wr_fire) begin
        if (ptr_last_col) begin
          wr_col_q <= '0;
          wr_row_q <= ptr_last_row ? '0 : wr_row_q + ROW_W'(1);
        end else begin
          wr_col_q <= wr_col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_col   <= '0;
      mem_row   <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= wr_fire;
      mem_re <= rd_fire && rd_in_range;
      if (wr_fire) begin
        mem_col   <= wr_col_q;
        mem_row   <= wr_row_q;
        mem_wdata <= wr_data;
      end else if (rd_fire && rd_in_range) begin
        mem_col <= rd_col;
        mem_row <= rd_row;
      end
    end
  end

  // Read return pipeline: grant -> mem_re cycle -> mem_rdata cycle -> rd_data.
  // Out-of-range reads ride the same pipe so responses stay in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_q       <= 1'b0;
      rd_err1_q     <= 1'b0;
      rd_v2_q       <= 1'b0;
      rd_err2_q     <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_err        <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_v1_q       <= rd_fire;
      rd_err1_q     <= rd_fire && !rd_in_range;
      rd_v2_q       <= rd_v1_q;
      rd_err2_q     <= rd_err1_q;
      rd_data_valid <= rd_v2_q;
      rd_err        <= rd_v2_q && rd_err2_q;
      if (rd_v2_q) rd_data <= rd_err2_q ? '0 : mem_rdata;
    end
  end

endmodule
